mine_placer: RTL
================

MINE_PLACER -- requirements
Module: mine_placer

Interface
REQ-001 SHALL have parameter ROWS, default 5, board rows (2..16).
REQ-002 SHALL have parameter COLS, default 5, board columns (2..16); CELLS = ROWS*COLS; IW = clog2(CELLS).
REQ-003 SHALL have port in_clka, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port in_reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port in_start, input, 1, request a new placement; sampled only in IDLE.
REQ-006 SHALL have port in_seed, input, 16, initial LCG state X0.
REQ-007 SHALL have port in_mult, input, 16, LCG multiplier a.
REQ-008 SHALL have port in_increment, input, 16, LCG increment c.
REQ-009 SHALL have port in_mines_num, input, IW+1, requested mine count.
REQ-010 SHALL have port in_safe_idx, input, IW, cell index that never receives a mine (used only with SAFE_CELL_EN).
REQ-011 SHALL have port out_mines, output, CELLS, bit i = 1 when cell i holds a mine.
REQ-012 SHALL have port out_busy, output, 1, high from LOAD through the last evaluation cycle.
REQ-013 SHALL have port out_done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port out_count, output, IW+1, mines placed so far.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, DRAW, PROBE, DONE.
REQ-016 IDLE with in_start=1 SHALL go to LOAD; in_start in any other state SHALL be ignored.
REQ-017 LOAD SHALL latch seed, a, c and the target; clear out_mines and out_count; and go to DONE if the target is 0, else to DRAW.
REQ-018 Target SHALL be min(in_mines_num, LIMIT), where LIMIT = CELLS-1 with SAFE_CELL_EN and CELLS without it.
REQ-019 Each DRAW cycle SHALL compute Xn = (a*X + c) mod 2^16, store X <= Xn, and take candidate = (Xn[15:8]*CELLS) >> 8, which always lies in 0..CELLS-1.
REQ-020 An evaluated cell that is free and not excluded SHALL have its bit set and out_count incremented in the same cycle; the FSM then goes to DONE if the count reaches the target, else to DRAW.
REQ-021 An evaluated cell that is occupied or excluded SHALL send the FSM to PROBE with index+1, wrapping from CELLS-1 to 0; PROBE SHALL evaluate one cell per cycle and shall not advance X.
REQ-022 DONE SHALL assert out_done for exactly one cycle and then return to IDLE; out_mines and out_count SHALL hold until the next LOAD.
REQ-023 Placement SHALL terminate within target*CELLS evaluation cycles; REQ-018 guarantees that a free cell exists.
REQ-024 Results SHALL be fully deterministic for a given (seed, a, c, target, safe_idx).

Reset
REQ-025 in_reset SHALL immediately force state IDLE, X=0, out_mines=0, out_count=0, out_busy=0, out_done=0, including mid-placement.
REQ-026 After reset release, the first in_start SHALL be accepted on the next rising edge.

Configuration
REQ-027 Macro SAFE_CELL_EN defined: in_safe_idx is excluded per REQ-021 and LIMIT = CELLS-1.
REQ-028 Macro SAFE_CELL_EN undefined: in_safe_idx is unused, no cell is excluded and LIMIT = CELLS.

Structure
REQ-029 Package mine_pkg SHALL hold the FSM state enum, LCG width constant (16) and clog2 helper.
REQ-030 Sub-module mine_lcg SHALL hold X, the a*X+c update and the candidate scaling; mine_placer holds FSM, occupancy and probing.

Verification
REQ-031 Defaults, a=0, c=7, seed=0, mines=3, no SAFE_CELL_EN -> every candidate is 0; out_mines=25'h0000007; out_count=3; 1 LOAD + 6 evaluation cycles; then out_done pulses once.
REQ-032 Same stimulus with SAFE_CELL_EN and safe_idx=1 -> out_mines has bits 0, 2 and 3 set (25'h000000D); out_count=3.
REQ-033 mines=30, a=0, c=7, no SAFE_CELL_EN -> target clamps to 25; out_mines=all ones; out_count=25; out_done pulses.
REQ-034 mines=0 -> LOAD then DONE; out_mines=0; out_done pulses in the 2nd cycle after in_start is sampled.
REQ-035 in_start pulsed while out_busy=1 -> ignored; result is identical to a single start.
REQ-036 in_reset asserted after 2 mines are placed -> outputs 0 immediately; a fresh start with the same inputs reproduces the REQ-031 result.

Source files
------------

// File: rtl/mine_pkg.sv
// Shared types and helpers for the mine placer: FSM state encoding, LCG width
// and a constant-foldable ceil(log2) used to size index ports.
`timescale 1ns/1ps
package mine_pkg;
    localparam int LCG_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAW,
        PROBE,
        DONE
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/mine_lcg.sv
// 16-bit linear congruential generator with candidate scaling to 0..CELLS-1.
// The candidate is derived from the next state so a DRAW cycle evaluates it immediately.
`timescale 1ns/1ps
module mine_lcg
    import mine_pkg::*;
#(
    parameter int CELLS = 25,
    parameter int IW    = clog2(CELLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [LCG_W-1:0] seed,
    input  logic [LCG_W-1:0] mult,
    input  logic [LCG_W-1:0] increment,
    output logic [IW-1:0]    candidate
);
    logic [LCG_W-1:0] x_reg;
    logic [LCG_W-1:0] a_reg;
    logic [LCG_W-1:0] c_reg;
    logic [LCG_W-1:0] x_next;

    assign x_next = a_reg * x_reg + c_reg;

    // Upper byte times CELLS, divided by 256: uniform-ish and always < CELLS.
    assign candidate = IW'((32'(x_next[LCG_W-1:8]) * 32'(CELLS)) >> 8);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg <= '0;
            a_reg <= '0;
            c_reg <= '0;
        end else if (load) begin
            x_reg <= seed;
            a_reg <= mult;
            c_reg <= increment;
        end else if (step) begin
            x_reg <= x_next;
        end
    end
endmodule

// File: rtl/mine_placer.sv
// Places up to ROWS*COLS mines using an LCG with linear probing on collisions.
// Define SAFE_CELL_EN to keep in_safe_idx free of mines (limit becomes CELLS-1).
`timescale 1ns/1ps
module mine_placer
    import mine_pkg::*;
#(
    parameter  int ROWS  = 5,
    parameter  int COLS  = 5,
    localparam int CELLS = ROWS * COLS,
    localparam int IW    = clog2(CELLS)
) (
    input  logic             in_clka,
    input  logic             in_reset,
    input  logic             in_start,
    input  logic [LCG_W-1:0] in_seed,
    input  logic [LCG_W-1:0] in_mult,
    input  logic [LCG_W-1:0] in_increment,
    input  logic [IW:0]      in_mines_num,
    input  logic [IW-1:0]    in_safe_idx,
    output logic [CELLS-1:0] out_mines,
    output logic             out_busy,
    output logic             out_done,
    output logic [IW:0]      out_count
);
`ifdef SAFE_CELL_EN
    localparam logic [IW:0] LIMIT = (IW+1)'(CELLS - 1);
`else
    localparam logic [IW:0] LIMIT = (IW+1)'(CELLS);
`endif
    localparam logic [IW-1:0] LAST_IDX = IW'(CELLS - 1);

    state_t           state_reg;
    logic [CELLS-1:0] mines_reg;
    logic [IW:0]      count_reg;
    logic [IW:0]      target_reg;
    logic [IW-1:0]    probe_idx_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [IW-1:0]    candidate;
    logic [IW-1:0]    eval_idx;
    logic [IW-1:0]    next_idx;
    logic [IW:0]      target_value;
    logic [IW:0]      count_next;
    logic             cell_blocked;
    logic             excluded;

    mine_lcg #(
        .CELLS (CELLS),
        .IW    (IW)
    ) u_lcg (
        .clk       (in_clka),
        .rst       (in_reset),
        .load      (state_reg == LOAD),
        .step      (state_reg == DRAW),
        .seed      (in_seed),
        .mult      (in_mult),
        .increment (in_increment),
        .candidate (candidate)
    );

`ifdef SAFE_CELL_EN
    logic [IW-1:0] safe_reg;
    assign excluded = (eval_idx == safe_reg);
`else
    logic unused_safe_idx;
    assign unused_safe_idx = ^in_safe_idx;
    assign excluded        = 1'b0;
`endif

    assign target_value = (in_mines_num > LIMIT) ? LIMIT : in_mines_num;
    assign eval_idx     = (state_reg == DRAW) ? candidate : probe_idx_reg;
    assign next_idx     = (eval_idx == LAST_IDX) ? '0 : eval_idx + 1'b1;
    assign cell_blocked = mines_reg[eval_idx] | excluded;
    assign count_next   = count_reg + 1'b1;

    always_ff @(posedge in_clka or posedge in_reset) begin
        if (in_reset) begin
            state_reg     <= IDLE;
            mines_reg     <= '0;
            count_reg     <= '0;
            target_reg    <= '0;
            probe_idx_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef SAFE_CELL_EN
            safe_reg      <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_start) begin
                        state_reg <= LOAD;
                        busy_reg  <= 1'b1;
                    end
                end
                LOAD: begin
                    mines_reg  <= '0;
                    count_reg  <= '0;
                    target_reg <= target_value;
`ifdef SAFE_CELL_EN
                    safe_reg   <= in_safe_idx;
`endif
                    if (target_value == '0) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= DRAW;
                    end
                end
                DRAW, PROBE: begin
                    if (cell_blocked) begin
                        // Collision: walk forward without consuming another random draw.
                        probe_idx_reg <= next_idx;
                        state_reg     <= PROBE;
                    end else begin
                        mines_reg[eval_idx] <= 1'b1;
                        count_reg           <= count_next;
                        if (count_next == target_reg) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= DRAW;
                        end
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign out_mines = mines_reg;
    assign out_count = count_reg;
    assign out_busy  = busy_reg;
    assign out_done  = done_reg;
endmodule
